mode_select_sequencer: RTL and testbench

Parametrised mode-to-select sequencer. It accepts a mode request over a valid/ready handshake, maps the mode to one of NUM_SEL select lines through a configurable table, and drives registered one-hot selects. Switching between two different selects is break-before-make: all selects are held low for DEAD_CYCLES clocks. It sits between the mode-control logic and the datapath muxes, as the next generation of the combinational mode one-hot encoder.

---
 rtl/mode_sel_pkg.sv | 25 ++
 rtl/dead_time_counter.sv | 24 ++
 rtl/mode_select_sequencer.sv | 156 +++++++++++++++
 tb/tb_mode_select_sequencer.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/mode_sel_pkg.sv
// Shared types, default mode-to-select table and helpers for the mode select sequencer.
package mode_sel_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_BREAK  = 2'd2
    } state_e;

    // Entry m (LSB first) is the select index for mode m: modes 0,1->0, 2->1, 3->2.
    localparam logic [7:0] DEF_SEL_MAP = {2'd2, 2'd1, 2'd0, 2'd0};

    function automatic int mode_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [31:0] onehot(input int idx, input int width);
        logic [31:0] v;
        v = '0;
        if (idx >= 0 && idx < width && idx < 32)
            v = 32'd1 << idx;
        return v;
    endfunction

endpackage

// File: rtl/dead_time_counter.sv
// Loadable 8-bit down-counter that times the all-off gap between two selects.
module dead_time_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_load,
    input  logic [7:0] i_load_val,
    input  logic       i_en,
    output logic       o_zero
);

    logic [7:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_load_val;
        else if (i_en && r_cnt != 8'd0)
            r_cnt <= r_cnt - 8'd1;
    end

    assign o_zero = (r_cnt == 8'd0);

endmodule

// File: rtl/mode_select_sequencer.sv
// Mode request -> registered one-hot select with break-before-make dead time.
// Optional MODE_SEL_FORCE_OFF_EN adds a force_off input that sequences the selects off to IDLE.
module mode_select_sequencer
    import mode_sel_pkg::*;
#(
    parameter int NUM_MODES   = 4,
    parameter int NUM_SEL     = 3,
    parameter int DEAD_CYCLES = 2,
    parameter logic [NUM_MODES*$clog2(NUM_SEL)-1:0] SEL_MAP = DEF_SEL_MAP
) (
    input  logic                           clk,
    input  logic                           reset,
`ifdef MODE_SEL_FORCE_OFF_EN
    input  logic                           force_off,
`endif
    input  logic [mode_w(NUM_MODES)-1:0]   Mode_input,
    input  logic                           mode_valid,
    output logic                           mode_ready,
    output logic [NUM_SEL-1:0]             select,
    output logic [mode_w(NUM_MODES)-1:0]   cur_mode,
    output logic                           busy,
    output logic                           mode_err
);

    localparam int MODE_W    = mode_w(NUM_MODES);
    localparam int SEL_W     = $clog2(NUM_SEL);
    localparam int MAP_DEPTH = 1 << MODE_W;
    localparam logic [MODE_W:0] NUM_MODES_V = NUM_MODES[MODE_W:0];
    localparam logic [7:0]      DEAD_LOAD   = 8'(DEAD_CYCLES - 1);

    if (DEAD_CYCLES < 1 || DEAD_CYCLES > 255) begin : g_bad_dead
        $error("DEAD_CYCLES must be in 1..255");
    end
    if (NUM_SEL < 2) begin : g_bad_nsel
        $error("NUM_SEL must be at least 2");
    end

    // Pad the table to the full code space so any Mode_input value indexes safely.
    logic [SEL_W-1:0] w_map [MAP_DEPTH];
    for (genvar m = 0; m < MAP_DEPTH; m++) begin : g_map
        if (m < NUM_MODES) begin : g_legal
            if (int'(SEL_MAP[m*SEL_W +: SEL_W]) >= NUM_SEL) begin : g_bad_entry
                $error("SEL_MAP entry out of range");
            end
            assign w_map[m] = SEL_MAP[m*SEL_W +: SEL_W];
        end else begin : g_pad
            assign w_map[m] = '0;
        end
    end

    state_e              r_state;
    logic [NUM_SEL-1:0]  r_sel;
    logic [MODE_W-1:0]   r_cur_mode;
    logic                r_err;
    logic [SEL_W-1:0]    r_tgt;
    logic [MODE_W-1:0]   r_tgt_mode;
    logic                r_tgt_none;

    logic                w_force_off;
    logic                w_ready;
    logic                w_acc;
    logic                w_legal;
    logic [SEL_W-1:0]    w_tgt;
    logic [31:0]         w_oh_req;
    logic [31:0]         w_oh_lat;
    logic                w_same;
    logic                w_start_break;
    logic                w_zero;

`ifdef MODE_SEL_FORCE_OFF_EN
    assign w_force_off = force_off;
`else
    assign w_force_off = 1'b0;
`endif

    assign w_ready  = (r_state == ST_IDLE || r_state == ST_ACTIVE) && !w_force_off;
    assign w_acc    = mode_valid && w_ready;
    assign w_legal  = ({1'b0, Mode_input} < NUM_MODES_V);
    assign w_tgt    = w_map[Mode_input];
    assign w_oh_req = onehot(int'(w_tgt), NUM_SEL);
    assign w_oh_lat = onehot(int'(r_tgt), NUM_SEL);
    assign w_same   = (r_sel == w_oh_req[NUM_SEL-1:0]);

    assign w_start_break = (r_state == ST_ACTIVE) &&
                           (w_force_off || (w_acc && w_legal && !w_same));

    dead_time_counter u_dead (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_start_break),
        .i_load_val (DEAD_LOAD),
        .i_en       (r_state == ST_BREAK),
        .o_zero     (w_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_sel      <= '0;
            r_cur_mode <= '0;
            r_err      <= 1'b0;
            r_tgt      <= '0;
            r_tgt_mode <= '0;
            r_tgt_none <= 1'b0;
        end else begin
            r_err <= w_acc && !w_legal;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_acc && w_legal) begin
                        r_state    <= ST_ACTIVE;
                        r_sel      <= w_oh_req[NUM_SEL-1:0];
                        r_cur_mode <= Mode_input;
                    end
                end
                ST_ACTIVE: begin
                    if (w_force_off) begin
                        r_state    <= ST_BREAK;
                        r_sel      <= '0;
                        r_tgt_none <= 1'b1;
                    end else if (w_acc && w_legal) begin
                        if (w_same) begin
                            r_cur_mode <= Mode_input;
                        end else begin
                            r_state    <= ST_BREAK;
                            r_sel      <= '0;
                            r_tgt      <= w_tgt;
                            r_tgt_mode <= Mode_input;
                            r_tgt_none <= 1'b0;
                        end
                    end
                end
                ST_BREAK: begin
                    if (w_zero) begin
                        if (r_tgt_none || w_force_off) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_state    <= ST_ACTIVE;
                            r_sel      <= w_oh_lat[NUM_SEL-1:0];
                            r_cur_mode <= r_tgt_mode;
                        end
                    end else if (w_force_off) begin
                        r_tgt_none <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign mode_ready = w_ready;
    assign select     = r_sel;
    assign cur_mode   = r_cur_mode;
    assign busy       = (r_state == ST_BREAK);
    assign mode_err   = r_err;

endmodule

// File: tb/tb_mode_select_sequencer.sv
// Self-checking bench: directed literal checks plus randomized traffic against a behavioural model.
module tb_mode_select_sequencer;

    localparam int NUM_MODES = 5;
    localparam int NUM_SEL   = 3;
    localparam int DEAD      = 2;
    localparam logic [9:0] MAP = {2'd1, 2'd2, 2'd1, 2'd0, 2'd0};

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       mode_valid = 1'b0;
    logic [2:0] Mode_input = '0;
`ifdef MODE_SEL_FORCE_OFF_EN
    logic       force_off = 1'b0;
`endif
    logic       mode_ready;
    logic [2:0] select;
    logic [2:0] cur_mode;
    logic       busy;
    logic       mode_err;

    int checks = 0;
    int errors = 0;

    int map_m [NUM_MODES] = '{0, 0, 1, 2, 1};

    // Model: current select (-1 none), mode, remaining all-off cycles and pending switch.
    int m_sel = -1;
    int m_mode = 0;
    int m_off = 0;
    int m_pend_sel = 0;
    int m_pend_mode = 0;
    bit m_err = 0;

    mode_select_sequencer #(
        .NUM_MODES   (NUM_MODES),
        .NUM_SEL     (NUM_SEL),
        .DEAD_CYCLES (DEAD),
        .SEL_MAP     (MAP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
`ifdef MODE_SEL_FORCE_OFF_EN
        .force_off  (force_off),
`endif
        .Mode_input (Mode_input),
        .mode_valid (mode_valid),
        .mode_ready (mode_ready),
        .select     (select),
        .cur_mode   (cur_mode),
        .busy       (busy),
        .mode_err   (mode_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic expect_out(input string nm, input logic [2:0] s, input logic [2:0] m,
                              input logic b, input logic r, input logic e);
        chk({nm, ".select"}, 32'(select), 32'(s));
        chk({nm, ".cur_mode"}, 32'(cur_mode), 32'(m));
        chk({nm, ".busy"}, 32'(busy), 32'(b));
        chk({nm, ".ready"}, 32'(mode_ready), 32'(r));
        chk({nm, ".err"}, 32'(mode_err), 32'(e));
    endtask

    task automatic step(input logic v, input logic [2:0] m);
        mode_valid = v;
        Mode_input = m;
        @(posedge clk);
        #1;
    endtask

    // Model update at each edge, comparison on the following falling edge.
    initial begin : compare
        int t;
        bit acc;
        logic [2:0] exp_sel;
        forever begin
            @(posedge clk);
            if (reset) begin
                m_sel = -1; m_mode = 0; m_off = 0; m_err = 0;
            end else begin
                acc   = mode_valid && (m_off == 0);
                m_err = acc && (int'(Mode_input) >= NUM_MODES);
                if (m_off > 0) begin
                    m_off--;
                    if (m_off == 0) begin
                        m_sel  = m_pend_sel;
                        m_mode = m_pend_mode;
                    end
                end else if (acc && !m_err) begin
                    t = map_m[int'(Mode_input)];
                    if (m_sel < 0 || m_sel == t) begin
                        m_sel  = t;
                        m_mode = int'(Mode_input);
                    end else begin
                        m_off       = DEAD;
                        m_pend_sel  = t;
                        m_pend_mode = int'(Mode_input);
                        m_sel       = -1;
                    end
                end
            end
            @(negedge clk);
            exp_sel = (m_sel < 0) ? 3'b000 : (3'b001 << m_sel);
            chk("model.select", 32'(select), 32'(exp_sel));
            chk("model.cur_mode", 32'(cur_mode), 32'(m_mode));
            chk("model.busy", 32'(busy), 32'(m_off > 0));
            chk("model.ready", 32'(mode_ready), 32'(m_off == 0));
            chk("model.err", 32'(mode_err), 32'(m_err));
            chk("onehot", 32'($countones(select) <= 1), 32'd1);
        end
    end

    initial begin : stim
        reset = 1'b1;
        step(0, 0);
        step(0, 0);
        expect_out("reset", 3'b000, 3'd0, 0, 1, 0);
        reset = 1'b0;
        step(1, 2);  expect_out("idle_req", 3'b010, 3'd2, 0, 1, 0);
        step(1, 0);  expect_out("brk_a1", 3'b000, 3'd2, 1, 0, 0);
        step(1, 0);  expect_out("brk_a2", 3'b000, 3'd2, 1, 0, 0);
        step(1, 0);  expect_out("make_a", 3'b001, 3'd0, 0, 1, 0);
        step(1, 1);  expect_out("same_tgt", 3'b001, 3'd1, 0, 1, 0);
        step(1, 3);  expect_out("brk_b1", 3'b000, 3'd1, 1, 0, 0);
        step(1, 3);  expect_out("brk_b2", 3'b000, 3'd1, 1, 0, 0);
        step(0, 0);  expect_out("make_b", 3'b100, 3'd3, 0, 1, 0);
        step(1, 6);  expect_out("oor_err", 3'b100, 3'd3, 0, 1, 1);
        step(0, 0);  expect_out("oor_clr", 3'b100, 3'd3, 0, 1, 0);
        step(1, 2);  expect_out("brk_c1", 3'b000, 3'd3, 1, 0, 0);
        reset = 1'b1;
        step(1, 2);  expect_out("rst_brk", 3'b000, 3'd0, 0, 1, 0);
        reset = 1'b0;
        step(1, 4);  expect_out("post_rst", 3'b010, 3'd4, 0, 1, 0);

        for (int i = 0; i < 800; i++) begin
            reset      = ($urandom_range(0, 59) == 0);
            mode_valid = ($urandom_range(0, 9) < 7);
            Mode_input = 3'($urandom_range(0, 7));
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        step(0, 0);
        step(0, 0);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
